// File: rtl/and_gate_sweep_ctrl_if.sv
// Signal bundle between the AND-gate sweep controller and its surroundings.
// master: the sweep controller (drives the gate inputs and status).
// slave:  the environment (issues start, returns the gate output).
interface and_gate_sweep_ctrl_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             gate_z;
  logic             gate_x;
  logic             gate_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [1:0]       fail_vec;

  modport master (
    input  start, gate_z,
    output gate_x, gate_y, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    output start, gate_z,
    input  gate_x, gate_y, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/and_gate_sweep_ctrl.sv
// On-chip test sequencer for a 2-input AND gate.
// A start pulse drives vectors 00,01,10,11 (PASSES times), holding each for
// HOLD_CYCLES cycles and sampling gate_z on the last hold cycle. Mismatches
// against x&y are counted (saturating) and the first failing vector is kept.
// Optional build macro AND_SWEEP_STOP_ON_FAIL_EN: stop at the first mismatch
// and keep driving the failing vector while in DONE.
module and_gate_sweep_ctrl #(
  parameter int HOLD_CYCLES = 5,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 4
) (
  input logic                   clk,
  input logic                   rst,
  and_gate_sweep_ctrl_if.master bus
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PCW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [PCW-1:0] PASS_LAST = PCW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       vec;
  logic [1:0]       vec_inc;
  logic [HCW-1:0]   hold_cnt;
  logic [PCW-1:0]   pass_cnt;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [1:0]       fail_vec;
  logic             gate_x;
  logic             gate_y;
  logic             accept;
  logic             sample;
  logic             mismatch;
  logic             last_vec;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign sample   = (state == DRIVE) && (hold_cnt == '0);
  assign mismatch = sample && (bus.gate_z != (vec[1] & vec[0]));
  assign last_vec = sample && (vec == 2'b11) && (pass_cnt == PASS_LAST);
  assign vec_inc  = vec + 2'd1;

  // Next-state decode for the sweep FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = DRIVE;
      DRIVE: begin
`ifdef AND_SWEEP_STOP_ON_FAIL_EN
        if (mismatch || last_vec) state_nxt = DONE;
`else
        if (last_vec) state_nxt = DONE;
`endif
      end
      DONE:  if (bus.start) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Vector sequencing, hold/pass counting, gate drive and error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= 2'b00;
      hold_cnt   <= '0;
      pass_cnt   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
      gate_x     <= 1'b0;
      gate_y     <= 1'b0;
    end else if (accept) begin
      vec        <= 2'b00;
      hold_cnt   <= HOLD_LAST;
      pass_cnt   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
      gate_x     <= 1'b0;
      gate_y     <= 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= vec;
        end
      end
      vec      <= vec_inc;
      hold_cnt <= HOLD_LAST;
      if (vec == 2'b11) pass_cnt <= pass_cnt + PCW'(1);
      if (state_nxt == DONE) begin
`ifdef AND_SWEEP_STOP_ON_FAIL_EN
        // A failing vector stays on the gate pins for probing.
        if (!mismatch) begin
          gate_x <= 1'b0;
          gate_y <= 1'b0;
        end
`else
        gate_x <= 1'b0;
        gate_y <= 1'b0;
`endif
      end else begin
        gate_x <= vec_inc[1];
        gate_y <= vec_inc[0];
      end
    end else if (state == DRIVE) begin
      hold_cnt <= hold_cnt - HCW'(1);
    end
  end

  assign bus.gate_x     = gate_x;
  assign bus.gate_y     = gate_y;
  assign bus.busy       = (state == DRIVE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = (state == DONE) && (err_count == '0);
  assign bus.err_count  = err_count;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule

// File: tb/tb_and_gate_sweep_ctrl.sv
// Bench for and_gate_sweep_ctrl: two instances (HOLD 5 / PASSES 1 and
// HOLD 1 / PASSES 8), each beside a gate described by a 4-entry truth table
// indexed by {x,y}. Expected results come from a sweep-level model.
module tb_and_gate_sweep_ctrl;

  localparam int H_A = 5;
  localparam int P_A = 1;
  localparam int H_B = 1;
  localparam int P_B = 8;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_S1  = 4'b1111;
  localparam logic [3:0] TT_S0  = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       start_s = '0;
  logic [1:0][3:0]  tt_s    = '0;
  logic [1:0][11:0] st;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  and_gate_sweep_ctrl_if #(.ERR_W(4)) ifa ();
  and_gate_sweep_ctrl_if #(.ERR_W(4)) ifb ();

  and_gate_sweep_ctrl #(.HOLD_CYCLES(H_A), .PASSES(P_A), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master)
  );
  and_gate_sweep_ctrl #(.HOLD_CYCLES(H_B), .PASSES(P_B), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master)
  );

  assign ifa.start  = start_s[0];
  assign ifb.start  = start_s[1];
  assign ifa.gate_z = tt_s[0][{ifa.gate_x, ifa.gate_y}];
  assign ifb.gate_z = tt_s[1][{ifb.gate_x, ifb.gate_y}];

  // status word: x y busy done pass fail_valid fail_vec[1:0] err_count[3:0]
  assign st[0] = {ifa.gate_x, ifa.gate_y, ifa.busy, ifa.done, ifa.pass,
                  ifa.fail_valid, ifa.fail_vec, ifa.err_count};
  assign st[1] = {ifb.gate_x, ifb.gate_y, ifb.busy, ifb.done, ifb.pass,
                  ifb.fail_valid, ifb.fail_vec, ifb.err_count};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep-level reference: a gate is judged per vector; the sweep outcome
  // follows from how many vectors are wrong and which one is first.
  task automatic model(input logic [3:0] tt, input int hold, input int passes,
                       output int errs, output bit fv, output logic [1:0] fvec,
                       output int dcyc, output logic [1:0] dxy);
    logic [3:0] bad;
    int first;
    int nbad;
    bad   = tt ^ TT_AND;
    first = -1;
    nbad  = 0;
    for (int v = 0; v < 4; v++) begin
      if (bad[v]) begin
        nbad++;
        if (first < 0) first = v;
      end
    end
    errs = nbad * passes;
    if (errs > 15) errs = 15;
    fv   = (first >= 0);
    fvec = fv ? 2'(first) : 2'b00;
    dcyc = 1 + 4 * hold * passes;
    dxy  = 2'b00;
`ifdef AND_SWEEP_STOP_ON_FAIL_EN
    if (fv) begin
      errs = 1;
      dcyc = 1 + hold * (first + 1);
      dxy  = fvec;
    end
`endif
  endtask

  task automatic run_sweep(input int w, input logic [3:0] tt, input int hold,
                           input int passes, input int busy_at, input int rst_at);
    int errs;
    bit fv;
    logic [1:0] fvec;
    logic [1:0] dxy;
    logic [1:0] v;
    int dcyc;
    int c;
    model(tt, hold, passes, errs, fv, fvec, dcyc, dxy);
    tt_s[w]    = tt;
    start_s[w] = 1'b1;
    tick();
    start_s[w] = 1'b0;
    c = 1;
    while (c < dcyc + 8) begin
      if (c == 1) begin
        check("accept_busy", 32'(st[w][9]), 1);
        check("accept_clear", {st[w][8], st[w][6:0]}, 0);
      end
      if (c == rst_at) begin
        rst = 1'b1;
        start_s[w] = 1'b0;
        tick();
        check("mid_rst_state", 32'(st[w]), 0);
        rst = 1'b0;
        return;
      end
      if (st[w][8]) break;
      v = 2'(((c - 1) / hold) % 4);
      check("drive_vec", 32'(st[w][11:10]), 32'(v));
      start_s[w] = (c == busy_at) && (c < dcyc - 1);
      tick();
      c++;
    end
    start_s[w] = 1'b0;
    check("done_cycle", c, dcyc);
    check("err_count", 32'(st[w][3:0]), errs);
    check("fail_valid", 32'(st[w][6]), 32'(fv));
    check("fail_vec", 32'(st[w][5:4]), 32'(fvec));
    check("pass", 32'(st[w][7]), 32'(errs == 0));
    check("busy_done", 32'(st[w][9]), 0);
    check("done_gate_xy", 32'(st[w][11:10]), 32'(dxy));
    tick();
    check("done_sticky", 32'(st[w][8]), 1);
  endtask

  initial begin
    logic [3:0] tt;
    int ba;
    repeat (3) tick();
    check("rst_a", 32'(st[0]), 0);
    check("rst_b", 32'(st[1]), 0);
    rst = 1'b0;
    tick();
    check("idle_a", 32'(st[0]), 0);

    run_sweep(0, TT_AND, H_A, P_A, 0, 0);
    run_sweep(0, TT_S1,  H_A, P_A, 0, 0);
    run_sweep(0, TT_OR,  H_A, P_A, 0, 0);
    run_sweep(0, TT_AND, H_A, P_A, 7, 0);
    run_sweep(0, TT_S1,  H_A, P_A, 0, 0);
    run_sweep(0, TT_AND, H_A, P_A, 0, 0);
    run_sweep(0, TT_S1,  H_A, P_A, 0, 12);
    tick();
    check("post_rst_idle", 32'(st[0]), 0);
    run_sweep(0, TT_AND, H_A, P_A, 0, 0);

    run_sweep(1, TT_S0,  H_B, P_B, 0, 0);
    run_sweep(1, TT_S1,  H_B, P_B, 0, 0);
    run_sweep(1, TT_AND, H_B, P_B, 5, 0);

    for (int i = 0; i < 6; i++) begin
      tt = 4'($urandom_range(0, 15));
      ba = $urandom_range(2, 19);
      run_sweep(0, tt, H_A, P_A, ba, 0);
      tt = 4'($urandom_range(0, 15));
      ba = $urandom_range(2, 30);
      run_sweep(1, tt, H_B, P_B, ba, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/and_gate_sweep_ctrl.md
Name: and_gate_sweep_ctrl

Overview:
- Self-checking sequencer for a 2-input AND gate instance (ports x, y → z).
- On a start pulse, drives all four input vectors (00, 01, 10, 11) in order, holds each vector for a programmable number of cycles, and samples z on the last hold cycle.
- Compares each sample against x&y, counts mismatches and captures the first failing vector.
- Sits beside the gate as its on-chip test controller, replacing a fixed-delay stimulus bench.

Parameters:
- HOLD_CYCLES, 5, cycles each vector is driven before z is sampled; legal range ≥1.
- PASSES, 1, number of full 4-vector sweeps per start; legal range ≥1.
- ERR_W, 4, width of the error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- gate_z  input  1  gate output under test
- gate_x  output  1  gate input x
- gate_y  output  1  gate input y
- busy  output  1  sweep in progress
- done  output  1  sweep finished; sticky until next accepted start or rst
- pass  output  1  done && err_count==0
- err_count  output  ERR_W  mismatch count, saturating at all-ones
- fail_valid  output  1  at least one mismatch seen this sweep
- fail_vec  output  2  {x,y} of first mismatch; valid when fail_valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: gate_x=0, gate_y=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=00. State returns to IDLE.
- rst has priority over every other input, including mid-sweep: the cycle after rst is sampled high, all outputs hold their reset values.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - gate_x/gate_y = 0.
  - start=1 at edge N → DRIVE, vec=00, hold_cnt=HOLD_CYCLES-1, pass_cnt=0, busy=1 from N+1.
- DRIVE:
  - gate_x=vec[1], gate_y=vec[0], both registered.
  - When hold_cnt≠0: hold_cnt decrements each cycle.
  - When hold_cnt==0: sample gate_z and compare with vec[1]&vec[0].
  - On mismatch: err_count increments, saturating. If fail_valid==0, set fail_valid=1 and fail_vec=vec.
  - After the sample, vec increments (wraps 11→00) and hold_cnt reloads to HOLD_CYCLES-1.
  - On vec==11 with pass_cnt==PASSES-1 → DONE. On vec==11 otherwise, pass_cnt increments.
- DONE:
  - busy=0, done=1, gate_x/gate_y return to 0; counters and capture registers hold.
  - start=1 → same transition as from IDLE. err_count, fail_valid and fail_vec clear on that same edge; done deasserts.
- Latency:
  - vec 00 appears on gate_x/gate_y at N+1.
  - Each vector occupies exactly HOLD_CYCLES cycles.
  - done rises at edge N+1+4·HOLD_CYCLES·PASSES.
- start while busy is ignored and does not perturb timing.
- Gate is combinational: z is settled within the hold window. With HOLD_CYCLES=1, sampling occurs in the same cycle the vector is driven.
- pass is combinational from done and err_count.

Optional Feature:
- Macro: AND_SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - First mismatch moves the FSM to DONE on the next edge; remaining vectors and passes are skipped.
  - gate_x/gate_y keep driving the failing vector while in DONE, for debug probing.
  - err_count = 1.
- Undefined:
  - Sweep always runs to completion; gate_x/gate_y = 0 in DONE.

Test Plan:
- Good gate (z=x&y), HOLD_CYCLES=5, PASSES=1, start pulse at cycle 0 → vectors 00/01/10/11 each held 5 cycles on cycles 1–20; done=1 at 21; pass=1; err_count=0; fail_valid=0.
- z stuck-at-1 → err_count=3, fail_valid=1, fail_vec=00, pass=0.
- Gate replaced by OR → err_count=2, fail_vec=01.
- start pulsed at cycle 7 while busy → ignored, done still at cycle 21. Then start in DONE → err_count/fail_valid clear, new sweep begins, done at cycle 21 relative to the new start.
- rst high at cycle 12 mid-sweep → cycle 13 all outputs at reset values, FSM in IDLE. Subsequent start runs a full clean sweep.
- PASSES=8, ERR_W=4:
  - Stuck-at-0 z → err_count=8, fail_vec=11.
  - Stuck-at-1 z → err_count saturates at 15.
  - Stuck-at-1 z with AND_SWEEP_STOP_ON_FAIL_EN → done at cycle HOLD_CYCLES+1, err_count=1, gate_x/gate_y held at 0/0.
